alu_sched: RTL

ALU_SCHED -- requirements
Module: alu_sched

---
 rtl/alu_sched_if.sv | 29 ++
 rtl/alu_sched.sv | 130 +++++++++++++
 2 files changed

// File: rtl/alu_sched_if.sv
// Handshake and ALU bus between two requesters, the scheduler and the shared ALU.
// slave: the scheduler side; master: the requesters, ALU and response consumer.
interface alu_sched_if;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  req0_op, req1_op;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  alu_opcode;
   logic [63:0] alu_out;
   logic        alu_carry;
   logic        rsp_valid, rsp_ready;
   logic [63:0] rsp_out;
   logic        rsp_carry, rsp_id, rsp_err;

   modport slave (
      input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op,
      input  alu_out, alu_carry, rsp_ready,
      output req0_ready, req1_ready, alu_a, alu_b, alu_opcode,
      output rsp_valid, rsp_out, rsp_carry, rsp_id, rsp_err
   );

   modport master (
      output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op,
      output alu_out, alu_carry, rsp_ready,
      input  req0_ready, req1_ready, alu_a, alu_b, alu_opcode,
      input  rsp_valid, rsp_out, rsp_carry, rsp_id, rsp_err
   );
endinterface

// File: rtl/alu_sched.sv
// Two-requester scheduler for a shared multi-cycle ALU (IDLE -> EXEC -> RESP).
// Define ALU_SCHED_RR_EN for round-robin arbitration; fixed priority (req0 wins) otherwise.
module alu_sched #(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32
) (
   input logic       clk,
   input logic       rst,
   alu_sched_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state, state_nxt;
   logic [5:0]  cnt;
   logic        grant0, grant1;
   logic        ready0, ready1, accept, acc_id;
   logic [3:0]  acc_op;
   logic [31:0] acc_a, acc_b;
   logic [5:0]  acc_lat;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  alu_opcode;
   logic [63:0] rsp_out;
   logic        rsp_carry, rsp_id, rsp_err;

`ifdef ALU_SCHED_RR_EN
   logic ptr;

   always_comb begin
      grant0 = bus.req0_valid & (~ptr | ~bus.req1_valid);
      grant1 = bus.req1_valid & (ptr | ~bus.req0_valid);
   end

   always_ff @(posedge clk) begin
      if (rst)         ptr <= 1'b0;
      else if (accept) ptr <= ~ptr;
   end
`else
   always_comb begin
      grant0 = bus.req0_valid;
      grant1 = bus.req1_valid & ~bus.req0_valid;
   end
`endif

   // a grant already implies the matching valid, so a ready is an accept
   assign accept  = ready0 | ready1;
   assign acc_id  = ready1;
   assign acc_op  = acc_id ? bus.req1_op : bus.req0_op;
   assign acc_a   = acc_id ? bus.req1_a  : bus.req0_a;
   assign acc_b   = acc_id ? bus.req1_b  : bus.req0_b;

   always_comb begin
      acc_lat = 6'd0;
      if (acc_op == 4'd2)      acc_lat = 6'(MUL_LAT - 1);
      else if (acc_op == 4'd3) acc_lat = 6'(DIV_LAT - 1);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = acc_op[3] ? RESP : EXEC;
         EXEC: if (cnt == 6'd0) state_nxt = RESP;
         RESP: if (bus.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready0        = 1'b0;
      ready1        = 1'b0;
      bus.rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            ready0 = grant0 & ~rst;
            ready1 = grant1 & ~rst;
         end
         RESP:    bus.rsp_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= 6'd0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= '0;
         rsp_out    <= '0;
         rsp_carry  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         if (accept) begin
            alu_a      <= acc_a;
            alu_b      <= acc_b;
            alu_opcode <= acc_op;
            rsp_id     <= acc_id;
            cnt        <= acc_lat;
            if (acc_op[3]) begin
               rsp_out   <= '0;
               rsp_carry <= 1'b0;
               rsp_err   <= 1'b1;
            end
         end
         if (state == EXEC) begin
            if (cnt == 6'd0) begin
               rsp_out   <= bus.alu_out;
               rsp_carry <= bus.alu_carry;
               rsp_err   <= 1'b0;
            end else begin
               cnt <= cnt - 6'd1;
            end
         end
      end
   end

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;
   assign bus.alu_a      = alu_a;
   assign bus.alu_b      = alu_b;
   assign bus.alu_opcode = alu_opcode;
   assign bus.rsp_out    = rsp_out;
   assign bus.rsp_carry  = rsp_carry;
   assign bus.rsp_id     = rsp_id;
   assign bus.rsp_err    = rsp_err;
endmodule
